// File: rtl/point_check_if.sv
// Request/response bundle for the point_check curve-membership validator.
// The master drives the curve, modulus and Montgomery constants; the slave returns status.
interface point_check_if #(
    parameter int LEN = 256
);
    logic           start;
    logic [LEN-1:0] a;
    logic [LEN-1:0] b;
    logic [LEN-1:0] p;
    logic [LEN-1:0] p_prime;
    logic [LEN-1:0] r2_mod_p;
    logic [LEN-1:0] x;
    logic [LEN-1:0] y;
    logic           busy;
    logic           done;
    logic           valid;

    modport master (
        output start, a, b, p, p_prime, r2_mod_p, x, y,
        input  busy, done, valid
    );

    modport slave (
        input  start, a, b, p, p_prime, r2_mod_p, x, y,
        output busy, done, valid
    );
endinterface

// File: rtl/point_check.sv
// Tests y^2 == x^3 + a*x + b (mod p) using one Montgomery product per clock.
// Fixed 11-cycle latency from accepted start to the done pulse.
module point_check #(
    parameter int LEN = 256
) (
    input  logic         clk,
    input  logic         rst,
    point_check_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        ADD1,
        ADD2,
        CMP
    } state_e;

    state_e         state_q, state_d;
    logic [2:0]     step_q;
    logic [LEN-1:0] a_q, b_q, p_q, pp_q, r2_q, x_q, y_q;
    logic [LEN-1:0] xm_q, ym_q, am_q, bm_q, y2_q, x2_q, x3_q, ax_q, s1_q, rhs_q;
    logic           valid_q, done_q;

    logic [LEN-1:0]   mm_a, mm_b, mm_res, m;
    logic [2*LEN-1:0] t, mp;
    logic             carry;
    logic [LEN:0]     u;
    logic [LEN-1:0]   add_a, add_b, add_res;
    logic [LEN:0]     s;
    logic             range_ok;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        mm_a = '0;
        mm_b = '0;
        unique case (step_q)
            3'd0: begin mm_a = x_q;  mm_b = r2_q; end
            3'd1: begin mm_a = y_q;  mm_b = r2_q; end
            3'd2: begin mm_a = a_q;  mm_b = r2_q; end
            3'd3: begin mm_a = b_q;  mm_b = r2_q; end
            3'd4: begin mm_a = ym_q; mm_b = ym_q; end
            3'd5: begin mm_a = xm_q; mm_b = xm_q; end
            3'd6: begin mm_a = x2_q; mm_b = xm_q; end
            3'd7: begin mm_a = am_q; mm_b = xm_q; end
            default: ;
        endcase
    end

    // Low half of t + m*p is zero by construction, so only its carry into the high half matters.
    always_comb begin
        t      = {{LEN{1'b0}}, mm_a} * {{LEN{1'b0}}, mm_b};
        m      = t[LEN-1:0] * pp_q;
        mp     = {{LEN{1'b0}}, m} * {{LEN{1'b0}}, p_q};
        carry  = |mp[LEN-1:0];
        u      = {1'b0, t[2*LEN-1:LEN]} + {1'b0, mp[2*LEN-1:LEN]} + {{LEN{1'b0}}, carry};
        mm_res = (u >= {1'b0, p_q}) ? (u[LEN-1:0] - p_q) : u[LEN-1:0];
    end

    always_comb begin
        add_a = s1_q;
        add_b = bm_q;
        if (state_q == ADD1) begin
            add_a = x3_q;
            add_b = ax_q;
        end
        s       = {1'b0, add_a} + {1'b0, add_b};
        add_res = (s >= {1'b0, p_q}) ? (s[LEN-1:0] - p_q) : s[LEN-1:0];
    end

    assign range_ok = (x_q < p_q) & (y_q < p_q) & p_q[0];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = MUL;
            MUL:     if (step_q == 3'd7) state_d = ADD1;
            ADD1:    state_d = ADD2;
            ADD2:    state_d = CMP;
            CMP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: the operand/intermediate registers are reset too, so an aborted run leaves no stale data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q  <= '0;
            a_q     <= '0; b_q  <= '0; p_q  <= '0; pp_q <= '0;
            r2_q    <= '0; x_q  <= '0; y_q  <= '0;
            xm_q    <= '0; ym_q <= '0; am_q <= '0; bm_q <= '0;
            y2_q    <= '0; x2_q <= '0; x3_q <= '0; ax_q <= '0;
            s1_q    <= '0; rhs_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        p_q     <= bus.p;
                        pp_q    <= bus.p_prime;
                        r2_q    <= bus.r2_mod_p;
                        x_q     <= bus.x;
                        y_q     <= bus.y;
                        step_q  <= '0;
                        valid_q <= 1'b0;
                    end
                end
                MUL: begin
                    step_q <= step_q + 3'd1;
                    unique case (step_q)
                        3'd0: xm_q <= mm_res;
                        3'd1: ym_q <= mm_res;
                        3'd2: am_q <= mm_res;
                        3'd3: bm_q <= mm_res;
                        3'd4: y2_q <= mm_res;
                        3'd5: x2_q <= mm_res;
                        3'd6: x3_q <= mm_res;
                        3'd7: ax_q <= mm_res;
                        default: ;
                    endcase
                end
                ADD1: s1_q  <= add_res;
                ADD2: rhs_q <= add_res;
                CMP: begin
                    valid_q <= (y2_q == rhs_q) & range_ok;
                    done_q  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy  = (state_q != IDLE);
    assign bus.done  = done_q;
    assign bus.valid = valid_q;

endmodule

// File: tb/tb_point_check.sv
// Randomised bench for point_check: curve membership is predicted with plain modular arithmetic.
module tb_point_check;

    localparam int LEN = 256;
    localparam logic [255:0] P256  = 256'hffffffff00000001000000000000000000000000ffffffffffffffffffffffff;
    localparam logic [255:0] A256  = 256'hffffffff00000001000000000000000000000000fffffffffffffffffffffffc;
    localparam logic [255:0] B256  = 256'h5ac635d8aa3a93e7b3ebbd55769886bc651d06b0cc53b0f63bce3c3e27d2604b;
    localparam logic [255:0] PP256 = 256'hffffffff00000002000000000000000000000001000000000000000000000001;
    localparam logic [255:0] GX    = 256'h6b17d1f2e12c4247f8bce6e563a440f277037d812deb33a0f4a13945d898c296;
    localparam logic [255:0] GY    = 256'h4fe342e2fe1a7f9b8ee7eb4a7c0f9e162bce33576b315ececbb6406837bf51f5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;
    logic [255:0] r2_c, pp_c;

    point_check_if #(.LEN(LEN)) bus ();
    point_check #(.LEN(LEN)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom())};
        return r;
    endfunction

    function automatic logic [255:0] mulmod(input logic [255:0] u, input logic [255:0] v, input logic [255:0] md);
        logic [511:0] w;
        w = {256'd0, u} * {256'd0, v};
        w = w % {256'd0, md};
        return w[255:0];
    endfunction

    function automatic logic [255:0] addmod(input logic [255:0] u, input logic [255:0] v, input logic [255:0] md);
        logic [256:0] w;
        w = {1'b0, u} + {1'b0, v};
        w = w % {1'b0, md};
        return w[255:0];
    endfunction

    function automatic logic [255:0] curve_rhs(input logic [255:0] ai, input logic [255:0] bi,
                                              input logic [255:0] md, input logic [255:0] xi);
        return addmod(addmod(mulmod(mulmod(xi, xi, md), xi, md), mulmod(ai % md, xi, md), md), bi % md, md);
    endfunction

    function automatic logic expect_valid(input logic [255:0] ai, input logic [255:0] bi, input logic [255:0] md,
                                          input logic [255:0] xi, input logic [255:0] yi);
        if (!(xi < md && yi < md && md[0])) return 1'b0;
        return mulmod(yi, yi, md) == curve_rhs(ai, bi, md, xi);
    endfunction

    // b that puts (xi, yi) on the curve with coefficient ai.
    function automatic logic [255:0] make_b(input logic [255:0] ai, input logic [255:0] xi, input logic [255:0] yi);
        logic [255:0] r0;
        r0 = curve_rhs(ai, 256'd0, P256, xi);
        return addmod(mulmod(yi, yi, P256), (P256 - r0) % P256, P256);
    endfunction

    function automatic logic [255:0] calc_pprime(input logic [255:0] md);
        logic [255:0] inv;
        inv = 256'd1;
        for (int i = 0; i < 9; i++) inv = inv * (256'd2 - md * inv);
        return -inv;
    endfunction

    function automatic logic [255:0] calc_r2(input logic [255:0] md);
        logic [512:0] w;
        w = 513'd1 << 512;
        w = w % {257'd0, md};
        return w[255:0];
    endfunction

    task automatic drive(input logic [255:0] ai, input logic [255:0] bi, input logic [255:0] pi,
                         input logic [255:0] xi, input logic [255:0] yi);
        bus.a = ai; bus.b = bi; bus.p = pi; bus.x = xi; bus.y = yi;
        bus.p_prime = pp_c; bus.r2_mod_p = r2_c;
    endtask

    // Issues one request from an idle/done cycle and reports latency and result; inputs are scrambled after acceptance.
    task automatic do_op(input logic [255:0] ai, input logic [255:0] bi, input logic [255:0] pi,
                         input logic [255:0] xi, input logic [255:0] yi,
                         output int lat, output logic v, output logic clr_ok);
        drive(ai, bi, pi, xi, yi);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        drive(rand256(), rand256(), rand256(), rand256(), rand256());
        clr_ok = (bus.busy === 1'b1) && (bus.valid === 1'b0) && (bus.done === 1'b0);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin
                lat = i;
                break;
            end
        end
        v = bus.valid;
    endtask

    task automatic test_reset();
        drive('0, '0, '0, '0, '0);
        bus.start = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
        n_total++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done); else n_pass++;
        n_total++; if (bus.valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.valid); else n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_generator();
        logic [255:0] ys [3];
        int lat; logic v, clr, ev;
        ys[0] = GY; ys[1] = P256 - GY; ys[2] = GY + 256'd1;
        for (int k = 0; k < 3; k++) begin
            ev = expect_valid(A256, B256, P256, GX, ys[k]);
            do_op(A256, B256, P256, GX, ys[k], lat, v, clr);
            n_total++; if (lat !== 11) $display("FAIL gen%0d_latency: got %0d want 11", k, lat); else n_pass++;
            n_total++; if (v !== ev) $display("FAIL gen%0d_valid: got %b want %b", k, v, ev); else n_pass++;
            n_total++; if (clr !== 1'b1) $display("FAIL gen%0d_accept: busy/valid after accept got %b want 1", k, clr); else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [255:0] ai, bi, xi, yi;
        int lat; logic v, clr, ev;
        for (int k = 0; k < 10; k++) begin
            xi = rand256() % P256;
            yi = rand256() % P256;
            ai = (k % 2 == 0) ? (rand256() >> 40) + P256 : rand256();
            bi = make_b(ai, xi, yi);
            if (k % 3 == 2) bi = addmod(bi, 256'd1 + (rand256() >> 200), P256);
            ev = expect_valid(ai, bi, P256, xi, yi);
            do_op(ai, bi, P256, xi, yi, lat, v, clr);
            n_total++; if (lat !== 11) $display("FAIL rand%0d_latency: got %0d want 11", k, lat); else n_pass++;
            n_total++; if (v !== ev) $display("FAIL rand%0d_valid: got %b want %b", k, v, ev); else n_pass++;
        end
    endtask

    task automatic test_range();
        logic [255:0] ai, bi, x0, y0;
        logic [255:0] xs [4], ys [4], ps [4];
        int lat; logic v, clr, ev;
        ai = rand256();
        x0 = rand256() >> 40;
        y0 = rand256() % P256;
        bi = make_b(ai, x0, y0);
        xs[0] = x0;        ys[0] = y0; ps[0] = P256;
        xs[1] = x0 + P256; ys[1] = y0; ps[1] = P256;
        y0 = rand256() >> 40;
        xs[2] = rand256() % P256; ys[2] = y0 + P256; ps[2] = P256;
        xs[3] = GX;        ys[3] = GY; ps[3] = P256 - 256'd1;
        for (int k = 0; k < 4; k++) begin
            logic [255:0] bk;
            bk = (k == 2) ? make_b(ai, xs[2], y0) : (k == 3) ? B256 : bi;
            ev = expect_valid((k == 3) ? A256 : ai, bk, ps[k], xs[k], ys[k]);
            do_op((k == 3) ? A256 : ai, bk, ps[k], xs[k], ys[k], lat, v, clr);
            n_total++; if (lat !== 11) $display("FAIL range%0d_latency: got %0d want 11", k, lat); else n_pass++;
            n_total++; if (v !== ev) $display("FAIL range%0d_valid: got %b want %b", k, v, ev); else n_pass++;
        end
    endtask

    task automatic test_busy_ignore();
        int n_done, first; logic v;
        n_done = 0; first = -1; v = 1'b0;
        drive(A256, B256, P256, GX, GY);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 1; i <= 25; i++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                n_done++;
                if (first < 0) begin first = i; v = bus.valid; end
            end
            if (i == 3) begin
                drive(A256, B256, P256, GX, GY + 256'd1);
                bus.start = 1'b1;
            end
        end
        n_total++; if (n_done !== 1) $display("FAIL busy_ignore_count: got %0d dones want 1", n_done); else n_pass++;
        n_total++; if (first !== 11) $display("FAIL busy_ignore_latency: got %0d want 11", first); else n_pass++;
        n_total++; if (v !== 1'b1) $display("FAIL busy_ignore_valid: got %b want 1", v); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int lat; logic v, clr;
        do_op(A256, B256, P256, GX, GY, lat, v, clr);
        n_total++; if (v !== 1'b1 || lat !== 11) $display("FAIL b2b_first: got lat %0d valid %b want 11/1", lat, v); else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL b2b_done_busy: got %b want 0", bus.busy); else n_pass++;
        do_op(A256, B256, P256, GX, GY + 256'd1, lat, v, clr);
        n_total++; if (lat !== 11) $display("FAIL b2b_latency: got %0d want 11", lat); else n_pass++;
        n_total++; if (clr !== 1'b1) $display("FAIL b2b_accept: valid cleared/busy got %b want 1", clr); else n_pass++;
        n_total++; if (v !== 1'b0) $display("FAIL b2b_valid: got %b want 0", v); else n_pass++;
    endtask

    task automatic test_reset_abort();
        int n_done, lat; logic v, clr;
        drive(A256, B256, P256, GX, GY);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", bus.busy); else n_pass++;
        n_total++; if (bus.valid !== 1'b0) $display("FAIL abort_valid: got %b want 0", bus.valid); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) n_done++;
        end
        n_total++; if (n_done !== 0) $display("FAIL abort_no_done: got %0d active cycles want 0", n_done); else n_pass++;
        do_op(A256, B256, P256, GX, GY, lat, v, clr);
        n_total++; if (lat !== 11) $display("FAIL abort_next_latency: got %0d want 11", lat); else n_pass++;
        n_total++; if (v !== 1'b1) $display("FAIL abort_next_valid: got %b want 1", v); else n_pass++;
    endtask

    initial begin
        pp_c = calc_pprime(P256);
        r2_c = calc_r2(P256);
        bus.start = 1'b0;
        test_reset();
        n_total++; if (pp_c !== PP256) $display("FAIL pprime_const: got %h want %h", pp_c, PP256); else n_pass++;
        test_generator();
        test_random();
        test_range();
        test_busy_ignore();
        test_back_to_back();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
